// File: rtl/line_raster_engine.sv
// Bresenham line rasteriser: buffers whole-line commands, walks one pixel per cycle and
// emits write-combined two-beat masked bursts to the DDR address/write-data FIFOs.
module line_raster_engine #(
  parameter int COORD_W       = 10,
  parameter int CMD_DEPTH     = 4,
  parameter int ENDPOINT_INCL = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2*COORD_W-1:0] cmd_p0,
  input  logic [2*COORD_W-1:0] cmd_p1,
  input  logic [23:0]          cmd_color,
  input  logic [31:0]          cmd_frame_base,
  input  logic                 af_full,
  input  logic                 wdf_full,
  output logic [30:0]          af_addr_din,
  output logic                 af_wr_en,
  output logic [127:0]         wdf_din,
  output logic [15:0]          wdf_mask_din,
  output logic                 wdf_wr_en,
  output logic                 busy,
  output logic [15:0]          lines_done
);

  localparam int AW      = $clog2(CMD_DEPTH);
  localparam int ENTRY_W = 4*COORD_W + 24 + 6;
  localparam int BLK_W   = 2*COORD_W + 5;
  localparam int ERR_W   = COORD_W + 2;

  localparam logic [COORD_W-1:0] C_ONE   = COORD_W'(1);
  localparam logic [COORD_W:0]   C_ONE_N = (COORD_W+1)'(1);
  localparam logic [COORD_W:0]   C_INCL  = (COORD_W+1)'(ENDPOINT_INCL);
  localparam logic [AW:0]        C_FULL  = (AW+1)'(CMD_DEPTH);
  localparam logic [AW-1:0]      C_PTR1  = AW'(1);
  localparam logic [AW:0]        C_CNT1  = (AW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STEP   = 3'd2,
    S_BURST0 = 3'd3,
    S_BURST1 = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // ---------------- command FIFO ----------------
  logic [ENTRY_W-1:0] r_mem [CMD_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_count;
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_push_data;
  logic               w_unused_base;

  // Only the 4 MB-aligned frame select bits reach the burst address.
  assign w_push_data   = {cmd_p0, cmd_p1, cmd_color, cmd_frame_base[27:22]};
  assign w_unused_base = ^{cmd_frame_base[31:28], cmd_frame_base[21:0]};
  assign cmd_ready     = (r_count != C_FULL);
  assign w_push        = cmd_valid && cmd_ready;
  assign w_pop         = (r_state == S_IDLE) && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT1;
        2'b01:   r_count <= r_count - C_CNT1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- working registers ----------------
  logic [COORD_W-1:0]     r_cx0, r_cy0, r_cx1, r_cy1;
  logic [23:0]            r_color;
  logic [5:0]             r_base;
  logic [COORD_W-1:0]     r_x, r_y, r_dx, r_dy;
  logic signed [ERR_W-1:0] r_err;
  logic                   r_steep;
  logic                   r_ystep_neg;
  logic [COORD_W:0]       r_remain;
  logic [31:0]            r_pending;
  logic [30:0]            r_burst_addr;
  logic [31:0]            r_burst_mask;
  logic                   r_line_last;
  logic [15:0]            r_lines;

  // ---------------- setup arithmetic ----------------
  logic [COORD_W-1:0] w_adx, w_ady;
  logic [COORD_W-1:0] w_sx0, w_sy0, w_sx1, w_sy1;
  logic [COORD_W-1:0] w_fx0, w_fy0, w_fx1, w_fy1;
  logic [COORD_W-1:0] w_dx, w_dy;
  logic               w_steep, w_swap, w_ystep_neg;
  logic [COORD_W:0]   w_npix;
  logic signed [ERR_W-1:0] w_err_init;

  assign w_adx   = (r_cx1 >= r_cx0) ? (r_cx1 - r_cx0) : (r_cx0 - r_cx1);
  assign w_ady   = (r_cy1 >= r_cy0) ? (r_cy1 - r_cy0) : (r_cy0 - r_cy1);
  assign w_steep = (w_ady > w_adx);

  // Steep lines are walked along y, so the major axis is always the incrementing "x".
  assign w_sx0 = w_steep ? r_cy0 : r_cx0;
  assign w_sy0 = w_steep ? r_cx0 : r_cy0;
  assign w_sx1 = w_steep ? r_cy1 : r_cx1;
  assign w_sy1 = w_steep ? r_cx1 : r_cy1;

  assign w_swap = (w_sx0 > w_sx1);
  assign w_fx0  = w_swap ? w_sx1 : w_sx0;
  assign w_fy0  = w_swap ? w_sy1 : w_sy0;
  assign w_fx1  = w_swap ? w_sx0 : w_sx1;
  assign w_fy1  = w_swap ? w_sy0 : w_sy1;

  assign w_dx        = w_fx1 - w_fx0;
  assign w_dy        = (w_fy1 >= w_fy0) ? (w_fy1 - w_fy0) : (w_fy0 - w_fy1);
  assign w_ystep_neg = !(w_fy1 > w_fy0);
  assign w_npix      = {1'b0, w_dx} + C_INCL;
  assign w_err_init  = $signed({3'b000, w_dx[COORD_W-1:1]});

  // ---------------- step arithmetic ----------------
  logic [COORD_W-1:0]      w_col, w_row, w_nx, w_ny, w_ncol, w_nrow;
  logic signed [ERR_W-1:0] w_e1, w_ne;
  logic                    w_take_y;
  logic [BLK_W-1:0]        w_cur_blk, w_next_blk;
  logic [30:0]             w_cur_addr;
  logic                    w_last, w_flush;
  logic [31:0]             w_clr;
  logic [31:0]             w_mask_new;

  assign w_col = r_steep ? r_y : r_x;
  assign w_row = r_steep ? r_x : r_y;

  assign w_nx     = r_x + C_ONE;
  assign w_e1     = r_err - $signed({2'b00, r_dy});
  assign w_take_y = w_e1[ERR_W-1];
  assign w_ny     = w_take_y ? (r_ystep_neg ? (r_y - C_ONE) : (r_y + C_ONE)) : r_y;
  assign w_ne     = w_take_y ? (w_e1 + $signed({2'b00, r_dx})) : w_e1;
  assign w_ncol   = r_steep ? w_ny : w_nx;
  assign w_nrow   = r_steep ? w_nx : w_ny;

  assign w_cur_blk  = {r_base, w_row, w_col[COORD_W-1:3], 2'b00};
  assign w_next_blk = {r_base, w_nrow, w_ncol[COORD_W-1:3], 2'b00};
  assign w_cur_addr = 31'(w_cur_blk);
  assign w_last     = (r_remain == C_ONE_N);
  assign w_flush    = w_last || (w_next_blk != w_cur_blk);

  // Pixel p of an 8-pixel block: beat p[2], nibble counted from the MSB by p[1:0].
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pix
      localparam int HI = (gi / 4) * 16 + 15 - 4 * (gi % 4);
      assign w_clr[HI -: 4] = {4{w_col[2:0] == 3'(gi)}};
    end
  endgenerate

  assign w_mask_new = r_pending & ~w_clr;

  // ---------------- FSM ----------------
  logic w_line_done;

  assign w_line_done = ((r_state == S_SETUP) && (w_npix == '0)) ||
                       ((r_state == S_BURST1) && !wdf_full && r_line_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    af_wr_en     = 1'b0;
    wdf_wr_en    = 1'b0;
    wdf_mask_din = 16'hFFFF;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) w_state_next = S_SETUP;
      end
      S_SETUP: begin
        w_state_next = (w_npix == '0) ? S_IDLE : S_STEP;
      end
      S_STEP: begin
        if (w_flush) w_state_next = S_BURST0;
      end
      S_BURST0: begin
        if (!af_full && !wdf_full) begin
          af_wr_en     = 1'b1;
          wdf_wr_en    = 1'b1;
          wdf_mask_din = r_burst_mask[15:0];
          w_state_next = S_BURST1;
        end
      end
      S_BURST1: begin
        if (!wdf_full) begin
          wdf_wr_en    = 1'b1;
          wdf_mask_din = r_burst_mask[31:16];
          w_state_next = r_line_last ? S_IDLE : S_STEP;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cx0        <= '0;
      r_cy0        <= '0;
      r_cx1        <= '0;
      r_cy1        <= '0;
      r_color      <= '0;
      r_base       <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_dx         <= '0;
      r_dy         <= '0;
      r_err        <= '0;
      r_steep      <= 1'b0;
      r_ystep_neg  <= 1'b0;
      r_remain     <= '0;
      r_pending    <= '1;
      r_burst_addr <= '0;
      r_burst_mask <= '1;
      r_line_last  <= 1'b0;
      r_lines      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_cx0, r_cy0, r_cx1, r_cy1, r_color, r_base} <= r_mem[r_rd_ptr];
          end
        end
        S_SETUP: begin
          r_x         <= w_fx0;
          r_y         <= w_fy0;
          r_dx        <= w_dx;
          r_dy        <= w_dy;
          r_err       <= w_err_init;
          r_steep     <= w_steep;
          r_ystep_neg <= w_ystep_neg;
          r_remain    <= w_npix;
          r_pending   <= '1;
        end
        S_STEP: begin
          r_x      <= w_nx;
          r_y      <= w_ny;
          r_err    <= w_ne;
          r_remain <= r_remain - C_ONE_N;
          if (w_flush) begin
            r_burst_addr <= w_cur_addr;
            r_burst_mask <= w_mask_new;
            r_pending    <= '1;
            r_line_last  <= w_last;
          end else begin
            r_pending <= w_mask_new;
          end
        end
        default: ;
      endcase
      if (w_line_done) r_lines <= r_lines + 16'd1;
    end
  end

  assign af_addr_din = r_burst_addr;
  assign wdf_din     = {4{8'h00, r_color}};
  assign busy        = (r_count != '0) || (r_state != S_IDLE);
  assign lines_done  = r_lines;

endmodule

// File: tb/tb_line_raster_engine.sv
// Self-checking bench for line_raster_engine: directed lines, FIFO fill, backpressure,
// randomized lines against a pixel-list reference model, and async reset mid-burst.
module tb_line_raster_engine;
  localparam int CW    = 10;
  localparam int DEPTH = 4;
  localparam int INCL  = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2*CW-1:0] cmd_p0 = '0;
  logic [2*CW-1:0] cmd_p1 = '0;
  logic [23:0]   cmd_color = '0;
  logic [31:0]   cmd_frame_base = '0;
  logic          af_full = 1'b0;
  logic          wdf_full = 1'b0;
  logic [30:0]   af_addr_din;
  logic          af_wr_en;
  logic [127:0]  wdf_din;
  logic [15:0]   wdf_mask_din;
  logic          wdf_wr_en;
  logic          busy;
  logic [15:0]   lines_done;

  always #5 clk = ~clk;

  line_raster_engine #(
    .COORD_W       (CW),
    .CMD_DEPTH     (DEPTH),
    .ENDPOINT_INCL (INCL)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_p0         (cmd_p0),
    .cmd_p1         (cmd_p1),
    .cmd_color      (cmd_color),
    .cmd_frame_base (cmd_frame_base),
    .af_full        (af_full),
    .wdf_full       (wdf_full),
    .af_addr_din    (af_addr_din),
    .af_wr_en       (af_wr_en),
    .wdf_din        (wdf_din),
    .wdf_mask_din   (wdf_mask_din),
    .wdf_wr_en      (wdf_wr_en),
    .busy           (busy),
    .lines_done     (lines_done)
  );

  typedef struct packed {
    logic [30:0] addr;
    logic [31:0] mask;
    logic [23:0] color;
  } burst_t;

  burst_t      exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_lines = 0;
  int          exp_bursts = 0;
  int          beats = 0;
  logic        expect_b1 = 1'b0;
  logic [15:0] b1_mask = '0;
  bit          bp_en = 1'b0;
  logic        force_af = 1'b0;
  logic        force_wdf = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [30:0] blk_addr(input int b, input int row, input int col);
    int a;
    a = (b << (2*CW-1)) | (row << (CW-1)) | ((col >> 3) << 2);
    return a[30:0];
  endfunction

  // Reference: list the line's pixels in walk order, then merge neighbours sharing a block.
  task automatic model_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input logic [23:0] color, input logic [31:0] base);
    int x0 = ax0, y0 = ay0, x1 = ax1, y1 = ay1;
    int t, dx, dy, err, ystep, y, n, col, row, p, hi;
    bit steep;
    bit have = 1'b0;
    logic [30:0] cur = '0;
    logic [30:0] a;
    logic [31:0] m = '1;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = (y1 > y0) ? y1 - y0 : y0 - y1;
    steep = (dy > dx);
    if (steep) begin
      t = x0; x0 = y0; y0 = t;
      t = x1; x1 = y1; y1 = t;
    end
    if (x0 > x1) begin
      t = x0; x0 = x1; x1 = t;
      t = y0; y0 = y1; y1 = t;
    end
    dx = x1 - x0;
    dy = (y1 > y0) ? y1 - y0 : y0 - y1;
    err = dx / 2;
    ystep = (y1 > y0) ? 1 : -1;
    y = y0;
    n = dx + INCL;
    for (int i = 0; i < n; i++) begin
      col = steep ? y : x0 + i;
      row = steep ? x0 + i : y;
      a = blk_addr(int'(base[27:22]), row, col);
      if (have && a != cur) begin
        exp_q.push_back('{cur, m, color});
        exp_bursts++;
        m = '1;
      end
      cur = a;
      have = 1'b1;
      p = col % 8;
      hi = (p / 4) * 16 + 15 - 4 * (p % 4);
      for (int k = 0; k < 4; k++) m[hi-k] = 1'b0;
      err -= dy;
      if (err < 0) begin
        y += ystep;
        err += dx;
      end
    end
    if (have) begin
      exp_q.push_back('{cur, m, color});
      exp_bursts++;
    end
    exp_lines++;
  endtask

  task automatic push_line(input int x0, input int y0, input int x1, input int y1,
                           input logic [23:0] color, input logic [31:0] base);
    int t = 0;
    model_line(x0, y0, x1, y1, color, base);
    @(negedge clk);
    while (!cmd_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("cmd_ready_wait", cmd_ready, 1'b1);
    cmd_p0         = {x0[CW-1:0], y0[CW-1:0]};
    cmd_p1         = {x1[CW-1:0], y1[CW-1:0]};
    cmd_color      = color;
    cmd_frame_base = base;
    cmd_valid      = 1'b1;
    @(negedge clk);
    cmd_valid      = 1'b0;
    $display("push (%0d,%0d)->(%0d,%0d) color %06h base %08h", x0, y0, x1, y1, color, base);
  endtask

  task automatic wait_idle(input int limit);
    int t = 0;
    while ((busy || exp_q.size() != 0 || expect_b1) && t < limit) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", (t < limit), 1'b1);
  endtask

  // Backpressure driver: random when bp_en, otherwise follows the forced levels.
  initial forever begin
    @(posedge clk);
    #2;
    if (bp_en) begin
      af_full  = ($urandom_range(0, 3) == 0);
      wdf_full = ($urandom_range(0, 2) == 0);
    end else begin
      af_full  = force_af;
      wdf_full = force_wdf;
    end
  end

  // Beat monitor against the expected burst queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (af_wr_en) begin
        check("af_with_wdf", wdf_wr_en, 1'b1);
        check("beat_order", expect_b1, 1'b0);
        beats++;
        if (exp_q.size() == 0) begin
          check("unexpected_burst", af_addr_din, 31'h7FFF_FFFF);
        end else begin
          burst_t e;
          e = exp_q.pop_front();
          check("burst_addr", af_addr_din, e.addr);
          check("mask_beat0", wdf_mask_din, e.mask[15:0]);
          check("wdf_data", wdf_din, {4{8'h00, e.color}});
          b1_mask   = e.mask[31:16];
          expect_b1 = 1'b1;
          $display("burst addr %07h mask %08h color %06h", af_addr_din, e.mask, e.color);
        end
      end else if (wdf_wr_en) begin
        check("beat1_pending", expect_b1, 1'b1);
        check("mask_beat1", wdf_mask_din, b1_mask);
        expect_b1 = 1'b0;
        beats++;
      end else begin
        check("idle_mask", wdf_mask_din, 16'hFFFF);
      end
    end
  end

  initial begin
    #900000;
    n_errors++;
    $display("FAIL global_timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  int dl [8][4];
  int n;
  int b0;
  int t;
  int ox, oy;

  initial begin
    dl = '{'{6, 0, 9, 0}, '{3, 0, 3, 3}, '{3, 3, 3, 0}, '{0, 0, 4, 2},
           '{4, 2, 0, 0}, '{2, 2, 2, 2}, '{1023, 1023, 1016, 1016}, '{1020, 3, 1023, 0}};

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_mask", wdf_mask_din, 16'hFFFF);
    check("rst_af_wr_en", af_wr_en, 1'b0);
    check("rst_wdf_wr_en", wdf_wr_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_lines_done", lines_done, 16'd0);
    check("rst_addr", af_addr_din, 31'd0);
    check("rst_wdf_din", wdf_din, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Aligned horizontal run: SETUP + 8 steps + 2 beats.
    push_line(0, 5, 7, 5, 24'h112233, 32'h0);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("horiz_latency", n, 12);
    wait_idle(100);
    check("lines_done_first", lines_done, 16'd1);

    for (int i = 0; i < 8; i++) begin
      push_line(dl[i][0], dl[i][1], dl[i][2], dl[i][3], 24'($urandom),
                (i == 6) ? 32'hFFFF_FFFF : 32'($urandom));
      wait_idle(500);
      check("lines_done_directed", lines_done, 16'(exp_lines));
    end

    // Address FIFO held full: nothing issued, commands pile up until the FIFO is full.
    force_af = 1'b1;
    b0 = beats;
    push_line(0, 9, 15, 9, 24'hA5A5A5, 32'h0040_0000);
    repeat (20) @(negedge clk);
    check("af_hold_no_beats", beats, b0);
    check("af_hold_busy", busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      push_line(8 * i, 20 + i, 8 * i + 5, 22 + i, 24'($urandom), 32'($urandom));
    end
    check("fifo_full_ready", cmd_ready, 1'b0);
    repeat (5) @(negedge clk);
    check("fifo_full_hold", cmd_ready, 1'b0);
    force_af = 1'b0;
    wait_idle(5000);
    check("fifo_drain_ready", cmd_ready, 1'b1);
    check("lines_done_fifo", lines_done, 16'(exp_lines));

    // Write-data FIFO full during beat 1 delays only the second beat.
    push_line(0, 40, 7, 40, 24'h0F0F0F, 32'h0);
    t = 0;
    while (!af_wr_en && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("beat0_seen", af_wr_en, 1'b1);
    force_wdf = 1'b1;
    #1;
    b0 = beats;
    repeat (3) @(negedge clk);
    #1;
    check("wdf_hold_beat1", beats, b0);
    force_wdf = 1'b0;
    wait_idle(200);

    // Randomized lines under random backpressure.
    bp_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ox = $urandom_range(0, 1023 - 64);
      oy = $urandom_range(0, 1023 - 64);
      push_line(ox + $urandom_range(0, 63), oy + $urandom_range(0, 63),
                ox + $urandom_range(0, 63), oy + $urandom_range(0, 63),
                24'($urandom), 32'($urandom));
      if ($urandom_range(0, 3) == 0) wait_idle(20000);
    end
    wait_idle(50000);
    bp_en = 1'b0;
    repeat (2) @(negedge clk);
    check("beats_paired", beats, 2 * exp_bursts);
    check("lines_done_random", lines_done, 16'(exp_lines));

    // Asynchronous reset while a burst is being issued.
    push_line(0, 100, 40, 100, 24'h777777, 32'h0);
    t = 0;
    while (!af_wr_en && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("reset_target_seen", af_wr_en, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_af_wr_en", af_wr_en, 1'b0);
    check("arst_wdf_wr_en", wdf_wr_en, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_lines_done", lines_done, 16'd0);
    check("arst_cmd_ready", cmd_ready, 1'b1);
    check("arst_mask", wdf_mask_din, 16'hFFFF);
    exp_q.delete();
    expect_b1 = 1'b0;
    exp_lines = 0;
    b0 = beats;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("post_reset_no_beats", beats, b0);
    check("post_reset_busy", busy, 1'b0);
    push_line(1, 1, 3, 2, 24'h123456, 32'h0);
    wait_idle(200);
    check("post_reset_lines", lines_done, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
